// File: rtl/bus_controller.sv
// Single-master data-bus controller: decodes core load/store requests onto four slaves,
// waits for ready with a bounded timeout and completes with a one-cycle grant or error.
module bus_controller #(
  parameter int unsigned TIMEOUT   = 255,
  parameter logic [31:0] ERR_RDATA = 32'hDEADBEEF
) (
  input  logic         i_CLK,
  input  logic         i_RST,
  input  logic         i_BUS_REQ,
  input  logic         i_BUS_WE,
  input  logic         i_BUS_RE,
  input  logic [31:0]  i_BUS_ADDR,
  input  logic [31:0]  i_BUS_WDATA,
  input  logic [1:0]   i_BUS_HB,
  output logic         o_BUS_GNT,
  output logic [31:0]  o_BUS_RDATA,
  output logic         o_BUS_ERR,
  output logic [3:0]   o_SEL,
  output logic [27:0]  o_ADDR,
  output logic [31:0]  o_WDATA,
  output logic [3:0]   o_BE,
  output logic         o_WE,
  output logic         o_RE,
  input  logic [127:0] i_RDATA,
  input  logic [3:0]   i_READY,
  input  logic         i_ERR_CLR,
  output logic         o_ERR_STICKY,
  output logic [31:0]  o_ERR_ADDR
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;
  localparam logic [1:0] ST_ERR    = 2'd3;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  logic [1:0]  r_state;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_we;
  logic        r_re;
  logic [1:0]  r_hb;
  logic [15:0] r_cnt;
  logic [31:0] r_rdata;
  logic        r_sticky;
  logic [31:0] r_err_addr;

  logic        w_bad;
  logic [1:0]  w_slot;
  logic        w_ready;
  logic [31:0] w_slave_word;
  logic [31:0] w_shifted;
  logic [31:0] w_aligned;
  logic        w_access;

  // Mapped slaves are 0..3 in ADDR[31:28], so ADDR[31:30] must be zero.
  assign w_bad = (i_BUS_WE == i_BUS_RE) || (i_BUS_HB == 2'b11) || (i_BUS_ADDR[31:30] != 2'b00)
              || ((i_BUS_HB == 2'b01) && i_BUS_ADDR[0])
              || ((i_BUS_HB == 2'b10) && (i_BUS_ADDR[1:0] != 2'b00));

  assign w_slot       = r_addr[29:28];
  assign w_ready      = i_READY[w_slot];
  assign w_slave_word = i_RDATA[{w_slot, 5'b00000} +: 32];
  assign w_shifted    = w_slave_word >> {r_addr[1:0], 3'b000};

  always_comb begin
    w_aligned = w_shifted;
    case (r_hb)
      2'b00:   w_aligned = {24'h000000, w_shifted[7:0]};
      2'b01:   w_aligned = {16'h0000, w_shifted[15:0]};
      default: w_aligned = w_shifted;
    endcase
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      r_state    <= ST_IDLE;
      r_addr     <= 32'h0;
      r_wdata    <= 32'h0;
      r_we       <= 1'b0;
      r_re       <= 1'b0;
      r_hb       <= 2'b00;
      r_cnt      <= 16'h0;
      r_rdata    <= 32'h0;
      r_sticky   <= 1'b0;
      r_err_addr <= 32'h0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_BUS_REQ) begin
            r_addr  <= i_BUS_ADDR;
            r_wdata <= i_BUS_WDATA;
            r_we    <= i_BUS_WE;
            r_re    <= i_BUS_RE;
            r_hb    <= i_BUS_HB;
            r_cnt   <= 16'h0;
            r_state <= w_bad ? ST_ERR : ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          // Ready takes priority over a timeout expiring in the same cycle.
          if (w_ready) begin
            r_rdata <= r_re ? w_aligned : 32'h0;
            r_state <= ST_RESP;
          end else if (r_cnt == TMO_LAST) begin
            r_state <= ST_ERR;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      if (r_state == ST_ERR) begin
        r_sticky   <= 1'b1;
        r_err_addr <= r_addr;
      end else if (i_ERR_CLR) begin
        r_sticky <= 1'b0;
      end
    end
  end

  assign w_access = (r_state == ST_ACCESS);

  always_comb begin
    o_SEL   = 4'b0000;
    o_ADDR  = 28'h0;
    o_WDATA = 32'h0;
    o_BE    = 4'b0000;
    if (w_access) begin
      o_SEL  = 4'b0001 << w_slot;
      o_ADDR = r_addr[27:0];
      case (r_hb)
        2'b00: begin
          o_BE    = 4'b0001 << r_addr[1:0];
          o_WDATA = {4{r_wdata[7:0]}};
        end
        2'b01: begin
          o_BE    = r_addr[1] ? 4'b1100 : 4'b0011;
          o_WDATA = {2{r_wdata[15:0]}};
        end
        default: begin
          o_BE    = 4'b1111;
          o_WDATA = r_wdata;
        end
      endcase
    end
  end

  assign o_WE         = w_access & r_we;
  assign o_RE         = w_access & r_re;
  assign o_BUS_GNT    = (r_state == ST_RESP) || (r_state == ST_ERR);
  assign o_BUS_ERR    = (r_state == ST_ERR);
  assign o_BUS_RDATA  = (r_state == ST_RESP) ? r_rdata :
                        (r_state == ST_ERR)  ? ERR_RDATA : 32'h0;
  assign o_ERR_STICKY = r_sticky;
  assign o_ERR_ADDR   = r_err_addr;

endmodule

// File: tb/tb_bus_controller.sv
// Bench for bus_controller: transaction-level model predicts every output each cycle,
// directed cases pin the model, then randomized traffic runs against it.
module tb_bus_controller;

  localparam int unsigned TMO = 4;
  localparam logic [31:0] ERRD = 32'hDEADBEEF;

  logic         clk;
  logic         i_RST, i_BUS_REQ, i_BUS_WE, i_BUS_RE, i_ERR_CLR;
  logic [31:0]  i_BUS_ADDR, i_BUS_WDATA;
  logic [1:0]   i_BUS_HB;
  logic [127:0] i_RDATA;
  logic [3:0]   i_READY;
  logic         o_BUS_GNT, o_BUS_ERR, o_WE, o_RE, o_ERR_STICKY;
  logic [31:0]  o_BUS_RDATA, o_WDATA, o_ERR_ADDR;
  logic [3:0]   o_SEL, o_BE;
  logic [27:0]  o_ADDR;

  bus_controller #(.TIMEOUT(TMO), .ERR_RDATA(ERRD)) dut (
    .i_CLK(clk), .i_RST(i_RST), .i_BUS_REQ(i_BUS_REQ), .i_BUS_WE(i_BUS_WE),
    .i_BUS_RE(i_BUS_RE), .i_BUS_ADDR(i_BUS_ADDR), .i_BUS_WDATA(i_BUS_WDATA),
    .i_BUS_HB(i_BUS_HB), .o_BUS_GNT(o_BUS_GNT), .o_BUS_RDATA(o_BUS_RDATA),
    .o_BUS_ERR(o_BUS_ERR), .o_SEL(o_SEL), .o_ADDR(o_ADDR), .o_WDATA(o_WDATA),
    .o_BE(o_BE), .o_WE(o_WE), .o_RE(o_RE), .i_RDATA(i_RDATA), .i_READY(i_READY),
    .i_ERR_CLR(i_ERR_CLR), .o_ERR_STICKY(o_ERR_STICKY), .o_ERR_ADDR(o_ERR_ADDR)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  bit force_clr = 1'b0;

  // Expected outputs for the current cycle.
  logic        exp_gnt, exp_err, exp_we, exp_re, exp_sticky;
  logic [31:0] exp_rdata, exp_wdata, exp_err_addr;
  logic [3:0]  exp_sel, exp_be;
  logic [27:0] exp_oaddr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("gnt", 32'(o_BUS_GNT), 32'(exp_gnt));
      chk("err", 32'(o_BUS_ERR), 32'(exp_err));
      chk("sel", 32'(o_SEL), 32'(exp_sel));
      chk("we", 32'(o_WE), 32'(exp_we));
      chk("re", 32'(o_RE), 32'(exp_re));
      chk("sticky", 32'(o_ERR_STICKY), 32'(exp_sticky));
      chk("err_addr", o_ERR_ADDR, exp_err_addr);
      if (exp_gnt) chk("rdata", o_BUS_RDATA, exp_rdata);
      if (exp_sel != 4'b0000) begin
        chk("addr", 32'(o_ADDR), 32'(exp_oaddr));
        chk("wdata", o_WDATA, exp_wdata);
        chk("be", 32'(o_BE), 32'(exp_be));
      end
    end
  end

  function automatic logic [3:0] be_of(input logic [1:0] hb, input logic [1:0] a);
    if (hb == 2'd0) return 4'(1 << a);
    if (hb == 2'd1) return (a >= 2) ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] wd_of(input logic [1:0] hb, input logic [31:0] w);
    longint unsigned b, h;
    b = longint'(w) % 256;
    h = longint'(w) % 65536;
    if (hb == 2'd0) return 32'(b * 32'h01010101);
    if (hb == 2'd1) return 32'(h * 32'h00010001);
    return w;
  endfunction

  function automatic logic [31:0] rd_of(input logic [1:0] hb, input logic [1:0] a,
                                        input logic [31:0] w);
    longint unsigned v;
    v = longint'(w) / (longint'(1) << (8 * int'(a)));
    if (hb == 2'd0) v = v % 256;
    else if (hb == 2'd1) v = v % 65536;
    return 32'(v);
  endfunction

  task automatic set_idle();
    exp_gnt = 0; exp_err = 0; exp_rdata = 0; exp_sel = 0; exp_we = 0; exp_re = 0;
    exp_oaddr = 0; exp_wdata = 0; exp_be = 0;
  endtask

  task automatic set_access(input logic [31:0] a, input logic we, input logic re,
                            input logic [1:0] hb, input logic [31:0] wd);
    exp_sel   = 4'(1 << int'(a[29:28]));
    exp_oaddr = a[27:0];
    exp_wdata = wd_of(hb, wd);
    exp_be    = be_of(hb, a[1:0]);
    exp_we    = we;
    exp_re    = re;
  endtask

  // Advance one clock, applying the sticky-status rules to the model.
  task automatic tick(input bit err_now, input logic [31:0] a);
    logic        nst;
    logic [31:0] nea;
    nea = exp_err_addr;
    if (err_now) begin
      nst = 1'b1;
      nea = a;
    end else begin
      nst = i_ERR_CLR ? 1'b0 : exp_sticky;
    end
    @(posedge clk);
    #1;
    exp_sticky   = nst;
    exp_err_addr = nea;
    i_ERR_CLR    = force_clr | ($urandom_range(0, 7) == 0);
  endtask

  // ready_at: ACCESS cycle number in which the slave is ready (0 = never).
  task automatic run_txn(input logic [31:0] a, input logic we, input logic re,
                         input logic [1:0] hb, input logic [31:0] wd, input int ready_at,
                         input logic [31:0] sdata, output int gnt_c,
                         output logic [31:0] m_rdata, output logic m_err);
    bit bad;
    bit hit;
    int c;
    logic [3:0] rdy;
    bad = (we == re) || (hb == 2'd3) || (a[31:28] > 4'd3) ||
          (hb == 2'd1 && (a % 2) != 0) || (hb == 2'd2 && (a % 4) != 0);
    i_BUS_REQ = 1; i_BUS_ADDR = a; i_BUS_WE = we; i_BUS_RE = re; i_BUS_HB = hb;
    i_BUS_WDATA = wd;
    i_READY = 4'($urandom);
    tick(0, 0);
    if (bad) begin
      set_idle();
      exp_gnt = 1; exp_err = 1; exp_rdata = ERRD;
      i_BUS_REQ = 0;
      gnt_c = 1; m_rdata = ERRD; m_err = 1;
      tick(1, a);
      set_idle();
      return;
    end
    c = 0;
    hit = 0;
    while (1) begin
      c++;
      set_access(a, we, re, hb, wd);
      rdy = 4'($urandom);
      rdy[a[29:28]] = (c == ready_at);
      i_READY = rdy;
      i_RDATA = {$urandom, $urandom, $urandom, $urandom};
      i_RDATA[32 * int'(a[29:28]) +: 32] = sdata;
      // Core-side inputs wander while the access is in flight.
      i_BUS_ADDR = $urandom; i_BUS_WDATA = $urandom; i_BUS_HB = 2'($urandom);
      i_BUS_WE = 1'($urandom); i_BUS_RE = 1'($urandom);
      hit = (c == ready_at);
      tick(0, 0);
      if (hit || c == int'(TMO)) break;
    end
    set_idle();
    exp_gnt = 1;
    i_BUS_REQ = 0;
    gnt_c = c + 1;
    if (hit) begin
      exp_rdata = re ? rd_of(hb, a[1:0], sdata) : 32'h0;
      m_rdata = exp_rdata; m_err = 0;
      tick(0, 0);
    end else begin
      exp_err = 1; exp_rdata = ERRD;
      m_rdata = ERRD; m_err = 1;
      tick(1, a);
    end
    set_idle();
  endtask

  int          g;
  logic [31:0] rd;
  logic        er;

  initial begin
    i_RST = 1; i_BUS_REQ = 0; i_BUS_WE = 0; i_BUS_RE = 0; i_BUS_ADDR = 0; i_BUS_WDATA = 0;
    i_BUS_HB = 0; i_RDATA = 0; i_READY = 0; i_ERR_CLR = 0;
    set_idle();
    exp_sticky = 0; exp_err_addr = 0;
    @(posedge clk); #1;
    chk_en = 1;
    @(posedge clk); #1;
    i_RST = 0;

    run_txn(32'h0000_0010, 0, 1, 2'd2, 32'h0, 3, 32'h11223344, g, rd, er);
    chk("t1_gnt_cycle", g, 4);
    chk("t1_rdata", rd, 32'h11223344);
    chk("t1_err", 32'(er), 0);
    chk("t1_be", 32'(be_of(2'd2, 2'd0)), 32'hF);

    run_txn(32'h1000_0003, 1, 0, 2'd0, 32'h0000_00A5, 1, 32'h0, g, rd, er);
    chk("t2_gnt_cycle", g, 2);
    chk("t2_be", 32'(be_of(2'd0, 2'd3)), 32'h8);
    chk("t2_wdata", wd_of(2'd0, 32'hA5), 32'hA5A5A5A5);

    run_txn(32'h2000_0002, 0, 1, 2'd1, 32'h0, 2, 32'hBEEF1234, g, rd, er);
    chk("t3_rdata", rd, 32'h0000BEEF);

    run_txn(32'h3000_0001, 0, 1, 2'd2, 32'h0, 1, 32'h0, g, rd, er);
    chk("t4_gnt_cycle", g, 1);
    chk("t4_rdata", rd, ERRD);
    chk("t4_err_addr", exp_err_addr, 32'h3000_0001);

    run_txn(32'h5000_0000, 0, 1, 2'd2, 32'h0, 1, 32'h0, g, rd, er);
    chk("t5_gnt_cycle", g, 1);
    chk("t5_err_addr", exp_err_addr, 32'h5000_0000);

    run_txn(32'h0000_0000, 0, 1, 2'd2, 32'h0, 0, 32'h0, g, rd, er);
    chk("t6_gnt_cycle", g, 5);
    chk("t6_err", 32'(er), 1);
    chk("t6_sticky", 32'(exp_sticky), 1);

    // Clear held across a new error completion: the error must win.
    force_clr = 1; i_ERR_CLR = 1;
    run_txn(32'h0000_0002, 1, 1, 2'd0, 32'h0, 1, 32'h0, g, rd, er);
    chk("t7_sticky", 32'(exp_sticky), 1);
    tick(0, 0);
    chk("t7_sticky_clr", 32'(exp_sticky), 0);
    chk("t7_err_addr", exp_err_addr, 32'h0000_0002);
    force_clr = 0;

    run_txn(32'h3000_0100, 0, 1, 2'd2, 32'h0, int'(TMO), 32'hCAFEF00D, g, rd, er);
    chk("t8_gnt_cycle", g, 5);
    chk("t8_err", 32'(er), 0);
    chk("t8_rdata", rd, 32'hCAFEF00D);

    // Reset in the second ACCESS cycle.
    i_READY = 0;
    i_BUS_REQ = 1; i_BUS_ADDR = 32'h0000_0020; i_BUS_WE = 0; i_BUS_RE = 1; i_BUS_HB = 2'd2;
    tick(0, 0);
    set_access(32'h0000_0020, 0, 1, 2'd2, i_BUS_WDATA);
    tick(0, 0);
    set_access(32'h0000_0020, 0, 1, 2'd2, i_BUS_WDATA);
    i_RST = 1;
    @(posedge clk); #1;
    i_RST = 0; i_BUS_REQ = 0;
    set_idle();
    exp_sticky = 0; exp_err_addr = 0;
    tick(0, 0);
    run_txn(32'h0000_0024, 0, 1, 2'd2, 32'h0, 1, 32'h0BADF00D, g, rd, er);
    chk("t9_gnt_cycle", g, 2);
    chk("t9_rdata", rd, 32'h0BADF00D);

    for (int n = 0; n < 300; n++) begin
      logic [31:0] a;
      logic [3:0]  top;
      logic        we, re;
      logic [1:0]  hb;
      int          r;
      top = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
      a = {top, 28'($urandom)};
      r = $urandom_range(0, 9);
      if (r == 0) begin we = 0; re = 0; end
      else if (r == 1) begin we = 1; re = 1; end
      else begin we = 1'($urandom); re = ~we; end
      hb = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      if ($urandom_range(0, 3) != 0) begin
        if (hb == 2'd1) a[0] = 1'b0;
        if (hb == 2'd2) a[1:0] = 2'b00;
      end
      run_txn(a, we, re, hb, $urandom, $urandom_range(0, 6), $urandom, g, rd, er);
      repeat ($urandom_range(0, 2)) tick(0, 0);
    end

    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
